// File: rtl/reg_wb_pkg.sv
// Shared constants and the ALU write-buffer entry type for the integer register-file
// write-back stage.
package reg_wb_pkg;

   localparam int unsigned REG_COUNT          = 32;
   localparam int unsigned REG_IDX_W          = 5;
   localparam int unsigned STARVE_MAX_DEFAULT = 4;
   localparam int unsigned WB_WIDTH           = 32;

   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic [WB_WIDTH-1:0]  data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Two-entry in-order buffer for ALU write-backs; entry 0 is always the head, and the
// per-entry rd/valid are exposed so the top can build the pending-destination mask.
module wb_fifo
   import reg_wb_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  wb_entry_t                 push_entry,
   input  logic                      pop,
   output wb_entry_t                 head,
   output logic [1:0]                count,
   output logic [1:0]                ent_valid,
   output logic [1:0][REG_IDX_W-1:0] ent_rd
);

   wb_entry_t  ent_q [2];
   wb_entry_t  ent_d [2];
   logic [1:0] count_q;
   logic [1:0] count_d;

   // Pop shifts entry 1 forward first, so a simultaneous push lands behind the survivor.
   always_comb begin
      ent_d[0] = ent_q[0];
      ent_d[1] = ent_q[1];
      count_d  = count_q;
      if (pop && (count_q != 2'd0)) begin
         ent_d[0] = ent_q[1];
         count_d  = count_q - 2'd1;
      end
      if (push && (count_d != 2'd2)) begin
         if (count_d == 2'd0) begin
            ent_d[0] = push_entry;
         end else begin
            ent_d[1] = push_entry;
         end
         count_d = count_d + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_q[0] <= '0;
         ent_q[1] <= '0;
         count_q  <= 2'd0;
      end else begin
         ent_q[0] <= ent_d[0];
         ent_q[1] <= ent_d[1];
         count_q  <= count_d;
      end
   end

   assign head      = ent_q[0];
   assign count     = count_q;
   assign ent_valid = {count_q == 2'd2, count_q != 2'd0};
   assign ent_rd    = {ent_q[1].rd, ent_q[0].rd};

endmodule

// File: rtl/reg_bank_wb.sv
// Integer register file with a single write port shared by the load unit (priority) and a
// buffered ALU path; per-destination ordering and bounded ALU starvation are enforced here.
module reg_bank_wb
   import reg_wb_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned BUF_DEPTH  = 2,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       alu_valid,
   output logic                       alu_ready,
   input  logic [REG_IDX_W-1:0]       alu_rd,
   input  logic [WIDTH-1:0]           alu_data,
   input  logic                       ld_valid,
   output logic                       ld_ready,
   input  logic [REG_IDX_W-1:0]       ld_rd,
   input  logic [WIDTH-1:0]           ld_data,
   output logic [REG_COUNT*WIDTH-1:0] regs_flat,
   output logic [REG_COUNT-1:0]       pend_mask,
   output logic [1:0]                 buf_count
);

   localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   logic [WIDTH-1:0]           regs_q [1:REG_COUNT-1];
   logic [CNT_W-1:0]           starve_q;
   logic [CNT_W-1:0]           starve_d;
   logic                       starve;
   logic                       alu_fire;
   logic                       fifo_push;
   logic                       fifo_pop;
   logic                       ld_fire;
   wb_entry_t                  push_entry;
   wb_entry_t                  head;
   logic [1:0]                 ent_valid;
   logic [1:0][REG_IDX_W-1:0]  ent_rd;
   logic                       wr_en;
   logic [REG_IDX_W-1:0]       wr_rd;
   logic [WIDTH-1:0]           wr_data;

   // rd==0 ALU results complete the handshake but never occupy a slot.
   assign alu_ready       = (buf_count != 2'(BUF_DEPTH));
   assign alu_fire        = alu_valid && alu_ready;
   assign fifo_push       = alu_fire && (alu_rd != '0);
   assign push_entry.rd   = alu_rd;
   assign push_entry.data = WB_WIDTH'(alu_data);

   wb_fifo u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (fifo_push),
      .push_entry (push_entry),
      .pop        (fifo_pop),
      .head       (head),
      .count      (buf_count),
      .ent_valid  (ent_valid),
      .ent_rd     (ent_rd)
   );

   always_comb begin
      pend_mask = '0;
      for (int e = 0; e < 2; e++) begin
         if (ent_valid[e]) begin
            pend_mask[ent_rd[e]] = 1'b1;
         end
      end
   end

   assign starve   = (starve_q == CNT_W'(STARVE_MAX));
   assign ld_ready = !(pend_mask[ld_rd] && (ld_rd != '0)) && !starve;
   assign ld_fire  = ld_valid && ld_ready;
   assign fifo_pop = !ld_fire && (buf_count != 2'd0);

   always_comb begin
      wr_en   = 1'b0;
      wr_rd   = '0;
      wr_data = '0;
      if (ld_fire) begin
         wr_en   = (ld_rd != '0);
         wr_rd   = ld_rd;
         wr_data = ld_data;
      end else if (fifo_pop) begin
         wr_en   = 1'b1;
         wr_rd   = head.rd;
         wr_data = WIDTH'(head.data);
      end
   end

   // Counts loads that win while the buffer is full; any pop restarts the window.
   always_comb begin
      starve_d = starve_q;
      if (fifo_pop) begin
         starve_d = '0;
      end else if (ld_fire && (buf_count == 2'd2)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < REG_COUNT; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[wr_rd] <= wr_data;
      end
   end

   assign regs_flat[WIDTH-1:0] = '0;
   for (genvar i = 1; i < REG_COUNT; i++) begin : g_flat
      assign regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
   end

endmodule

// File: tb/tb_reg_bank_wb.sv
// Directed and randomized checks of reg_bank_wb against a queue-based model of the
// write-back rules.
module tb_reg_bank_wb;

   localparam int W  = 32;
   localparam int SM = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          alu_valid = 1'b0;
   logic          alu_ready;
   logic [4:0]    alu_rd = '0;
   logic [W-1:0]  alu_data = '0;
   logic          ld_valid = 1'b0;
   logic          ld_ready;
   logic [4:0]    ld_rd = '0;
   logic [W-1:0]  ld_data = '0;
   logic [32*W-1:0] regs_flat;
   logic [31:0]   pend_mask;
   logic [1:0]    buf_count;

   always #5 clk = ~clk;

   reg_bank_wb #(
      .WIDTH      (W),
      .BUF_DEPTH  (2),
      .STARVE_MAX (SM)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_rd     (ld_rd),
      .ld_data   (ld_data),
      .regs_flat (regs_flat),
      .pend_mask (pend_mask),
      .buf_count (buf_count)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Model: architectural registers, an in-order queue of pending ALU writes, starve count.
   logic [W-1:0] m_regs [32];
   logic [4:0]   q_rd [$];
   logic [W-1:0] q_dat [$];
   int           scnt;
   logic         last_ld_fire;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      q_rd.delete();
      q_dat.delete();
      scnt = 0;
   endtask

   function automatic logic [31:0] m_pend();
      logic [31:0] m = '0;
      foreach (q_rd[k]) m[q_rd[k]] = 1'b1;
      return m;
   endfunction

   function automatic logic m_ld_ready(input logic [4:0] rd);
      logic [31:0] m = m_pend();
      return !((rd != 5'd0) && m[rd]) && (scnt != SM);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] dut_reg(input int i);
      return regs_flat[i*W +: W];
   endfunction

   task automatic check_all();
      chk("alu_ready", 32'(alu_ready), 32'(q_rd.size() < 2));
      chk("ld_ready", 32'(ld_ready), 32'(m_ld_ready(ld_rd)));
      chk("buf_count", 32'(buf_count), 32'(q_rd.size()));
      chk("pend_mask", pend_mask, m_pend());
      for (int i = 0; i < 32; i++) chk($sformatf("reg%0d", i), dut_reg(i), m_regs[i]);
   endtask

   // Check current outputs, then advance one clock and apply the write-back rules.
   task automatic cycle();
      logic         f_ld, f_alu;
      logic [4:0]   l_rd, a_rd;
      logic [W-1:0] l_dat, a_dat;
      #1;
      check_all();
      f_ld  = ld_valid && m_ld_ready(ld_rd);
      f_alu = alu_valid && (q_rd.size() < 2);
      l_rd  = ld_rd;  l_dat = ld_data;
      a_rd  = alu_rd; a_dat = alu_data;
      @(posedge clk);
      if (f_ld) begin
         if (l_rd != 5'd0) m_regs[l_rd] = l_dat;
         if (q_rd.size() == 2) scnt++;
      end else if (q_rd.size() > 0) begin
         m_regs[q_rd[0]] = q_dat[0];
         void'(q_rd.pop_front());
         void'(q_dat.pop_front());
         scnt = 0;
      end
      if (f_alu && (a_rd != 5'd0)) begin
         q_rd.push_back(a_rd);
         q_dat.push_back(a_dat);
      end
      last_ld_fire = f_ld;
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
   endtask

   task automatic fill_full();
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1A1_0001;
      cycle();
      alu_rd = 5'd2; alu_data = 32'hA2A2_0002;
      ld_valid = 1'b1; ld_rd = 5'd9; ld_data = $urandom;
      cycle();
      alu_valid = 1'b0;
   endtask

   initial begin
      int guard;
      model_reset();
      idle_inputs();
      last_ld_fire = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset then idle
      cycle();
      cycle();

      // ALU push rd=5; visible two edges later
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      cycle();
      idle_inputs();
      #1;
      chk("pend5_set", 32'(pend_mask[5]), 32'd1);
      cycle();
      chk("reg5_written", dut_reg(5), 32'hDEADBEEF);
      chk("pend5_clear", 32'(pend_mask[5]), 32'd0);

      // Load behind a buffered ALU write to the same register
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h11;
      cycle();
      alu_valid = 1'b0;
      ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h22;
      #1;
      chk("ld_blocked_rd7", 32'(ld_ready), 32'd0);
      guard = 0;
      do begin
         cycle();
         guard++;
      end while (!last_ld_fire && guard < 10);
      chk("ld_rd7_accepted", 32'(last_ld_fire), 32'd1);
      idle_inputs();
      cycle();
      chk("reg7_final", dut_reg(7), 32'h22);

      // rd=0 from both sources
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
      ld_valid  = 1'b1; ld_rd  = 5'd0; ld_data  = 32'hFFFFFFFF;
      cycle();
      idle_inputs();
      cycle();
      chk("reg0_zero", dut_reg(0), 32'd0);
      chk("rd0_no_slot", 32'(buf_count), 32'd0);

      // Starvation: full buffer, continuous loads to rd=9
      fill_full();
      for (int k = 1; k <= SM + 1; k++) begin
         ld_data = $urandom;
         #1;
         chk($sformatf("starve_ld_ready_c%0d", k), 32'(ld_ready), 32'(k != SM + 1));
         cycle();
      end
      chk("starve_rd1_retired", dut_reg(1), 32'hA1A1_0001);
      chk("starve_count_after", 32'(buf_count), 32'd1);
      for (int k = 0; k < 3; k++) begin
         ld_data = $urandom;
         cycle();
      end
      idle_inputs();
      cycle();
      chk("rd2_retired", dut_reg(2), 32'hA2A2_0002);
      cycle();

      // Reset with a full buffer
      fill_full();
      idle_inputs();
      #1 rst_n = 1'b0;
      #1;
      chk("rst_buf_count", 32'(buf_count), 32'd0);
      chk("rst_alu_ready", 32'(alu_ready), 32'd1);
      chk("rst_ld_ready", 32'(ld_ready), 32'd1);
      chk("rst_pend", pend_mask, 32'd0);
      chk("rst_reg2", dut_reg(2), 32'd0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) cycle();

      // Randomized traffic; loads stay stable until accepted
      for (int n = 0; n < 400; n++) begin
         alu_valid = 1'($urandom_range(0, 1));
         alu_rd    = 5'($urandom_range(0, 7));
         alu_data  = $urandom;
         if (!ld_valid || last_ld_fire) begin
            ld_valid = ($urandom_range(0, 2) != 0);
            ld_rd    = 5'($urandom_range(0, 7));
            ld_data  = $urandom;
         end
         cycle();
      end
      idle_inputs();
      repeat (3) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
